// File: rtl/prt.sv
// Packet reference table: true dual-port synchronous RAM, one shared clock.
// Write-first on each port's own output, read-first across ports; port A wins dual writes.
module prt #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  output logic [DATA_WIDTH-1:0] douta,
  input  logic                  web,
  input  logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] dinb,
  output logic [DATA_WIDTH-1:0] doutb
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  // Configuration-time contents are all zero; reset never touches the array.
  logic [DATA_WIDTH-1:0] mem [Depth] = '{default: '0};

  always_ff @(posedge clk) begin
    if (rst) begin
      douta <= '0;
      doutb <= '0;
    end else begin
      // Reads sample the pre-edge array, so the other port sees old data on a collision.
      douta <= wea ? dina : mem[addra];
      doutb <= web ? dinb : mem[addrb];
      // B is committed first so that A's write overrides it on a shared address.
      if (web) mem[addrb] <= dinb;
      if (wea) mem[addra] <= dina;
    end
  end

endmodule

// File: tb/tb_prt.sv
// Directed bench for prt: hand-computed vectors checked with immediate assertions.
module tb_prt;

  logic        clk = 1'b0;
  logic        rst;
  logic        wea;
  logic [15:0] addra;
  logic [0:0]  dina;
  logic [0:0]  douta;
  logic        web;
  logic [15:0] addrb;
  logic [0:0]  dinb;
  logic [0:0]  doutb;

  int vecs = 0;
  int errs = 0;

  prt dut (
    .clk   (clk),
    .rst   (rst),
    .wea   (wea),
    .addra (addra),
    .dina  (dina),
    .douta (douta),
    .web   (web),
    .addrb (addrb),
    .dinb  (dinb),
    .doutb (doutb)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [0:0] obs, input logic [0:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; wea = 1'b0; web = 1'b0;
    addra = 16'h0000; addrb = 16'h0000; dina = 1'b0; dinb = 1'b0;

    // Reset state
    tick();
    check("reset_douta", douta, 1'b0);
    check("reset_doutb", doutb, 1'b0);

    // Power-up contents are zero
    rst = 1'b0; addrb = 16'h0001;
    tick();
    check("init_0001", doutb, 1'b0);

    // Basic write; B reading the same address in that edge sees the old value
    wea = 1'b1; addra = 16'h0001; dina = 1'b1;
    tick();
    check("wr_first_a", douta, 1'b1);
    check("xread_old_b", doutb, 1'b0);
    wea = 1'b0;
    tick();
    check("rd_0001", doutb, 1'b1);
    addrb = 16'h0002;
    tick();
    check("rd_0002", doutb, 1'b0);

    // Multiple locations
    wea = 1'b1; addra = 16'h00A0; dina = 1'b1;
    tick();
    addra = 16'h00B0; dina = 1'b0;
    tick();
    wea = 1'b0; addrb = 16'h00A0;
    tick();
    check("rd_00a0", doutb, 1'b1);
    addrb = 16'h00B0;
    tick();
    check("rd_00b0", doutb, 1'b0);

    // Boundary addresses
    wea = 1'b1; addra = 16'h0000; dina = 1'b1;
    tick();
    addra = 16'hFFFF;
    tick();
    wea = 1'b0; addrb = 16'h0000;
    tick();
    check("rd_0000", doutb, 1'b1);
    check("rd_a_ffff", douta, 1'b1);
    addrb = 16'hFFFF; addra = 16'hFFFE;
    tick();
    check("rd_ffff", doutb, 1'b1);
    check("rd_a_fffe", douta, 1'b0);
    addrb = 16'h0002;
    tick();
    check("rd_0002_after", doutb, 1'b0);

    // Alternating pattern, back-to-back writes
    wea = 1'b1; addra = 16'h0100; dina = 1'b0;
    tick();
    addra = 16'h0101; dina = 1'b1;
    tick();
    wea = 1'b0; addrb = 16'h0100;
    tick();
    check("rd_0100", doutb, 1'b0);
    addrb = 16'h0101;
    tick();
    check("rd_0101", doutb, 1'b1);
    tick();
    check("hold_0101", doutb, 1'b1);

    // A writes while B reads the same address
    wea = 1'b1; addra = 16'h0F0F; dina = 1'b1; addrb = 16'h0F0F;
    tick();
    check("coll_b_old", doutb, 1'b0);
    check("coll_a_new", douta, 1'b1);
    wea = 1'b0;
    tick();
    check("coll_b_next", doutb, 1'b1);

    // B writes while A reads the same address
    web = 1'b1; addrb = 16'h0300; dinb = 1'b1; addra = 16'h0300;
    tick();
    check("coll_a_old", douta, 1'b0);
    check("coll_b_wf", doutb, 1'b1);
    web = 1'b0;
    tick();
    check("coll_a_next", douta, 1'b1);

    // Dual write: A's data stored, each port shows its own data
    wea = 1'b1; web = 1'b1; addra = 16'h0200; addrb = 16'h0200; dina = 1'b1; dinb = 1'b0;
    tick();
    check("dual_douta", douta, 1'b1);
    check("dual_doutb", doutb, 1'b0);
    wea = 1'b0; web = 1'b0;
    tick();
    check("dual_rd_b", doutb, 1'b1);
    check("dual_rd_a", douta, 1'b1);

    // Reset with a coincident write: outputs cleared, write discarded
    rst = 1'b1; wea = 1'b1; addra = 16'h0001; dina = 1'b0; addrb = 16'h0001;
    tick();
    check("rst1_douta", douta, 1'b0);
    check("rst1_doutb", doutb, 1'b0);
    tick();
    check("rst2_douta", douta, 1'b0);
    check("rst2_doutb", doutb, 1'b0);
    rst = 1'b0; wea = 1'b0;
    tick();
    check("post_rst_a", douta, 1'b1);
    check("post_rst_b", doutb, 1'b1);
    addrb = 16'h00A0;
    tick();
    check("post_rst_00a0", doutb, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
